// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Define HILO_MADD_EN to enable the MADD/MSUB accumulate state.
package hilo_pkg;

  localparam int   DATA_W_DEFAULT = 32;
  localparam logic HILO_RESET     = 1'b0;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
`ifdef HILO_MADD_EN
    ,
    ST_ACC
`endif
  } muldiv_state_t;

  typedef struct packed {
    muldiv_op_t op;
    logic       neg_p;
    logic       neg_r;
    logic       div0;
  } muldiv_ctx_t;

  function automatic logic op_signed(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_macc(input muldiv_op_t op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// acc/mplr form the 2*DATA_W working pair in both modes.
module muldiv_step
  import hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              mode_div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mplr,
  input  logic [DATA_W-1:0] opd,
  output logic [DATA_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] mplr_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] trial;

  assign sum   = {1'b0, acc} + (mplr[0] ? {1'b0, opd} : '0);
  assign trial = {acc, mplr[DATA_W-1]} - {1'b0, opd};

  always_comb begin
    acc_nxt  = acc;
    mplr_nxt = mplr;
    if (mode_div) begin
      // trial MSB set means the partial remainder was below the divisor
      if (!trial[DATA_W]) begin
        acc_nxt  = trial[DATA_W-1:0];
        mplr_nxt = {mplr[DATA_W-2:0], 1'b1};
      end else begin
        acc_nxt  = {acc[DATA_W-2:0], mplr[DATA_W-1]};
        mplr_nxt = {mplr[DATA_W-2:0], 1'b0};
      end
    end else begin
      {acc_nxt, mplr_nxt} = {sum, mplr[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, counter, sign fixup, HI/LO.
// Define HILO_MADD_EN to make ops 6/7 accumulate into {HI,LO}.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] RST_W = {DATA_W{HILO_RESET}};

  muldiv_state_t state_q, state_d;
  muldiv_ctx_t   ctx_q, ctx_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [DATA_W-1:0] opd_q, opd_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  muldiv_op_t        op_in;
  logic              sgn, neg_a, neg_b;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic              mode_div;
  logic [DATA_W-1:0] step_acc, step_mplr;

  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0]   quo_s, rem_s;
  logic                fix_div0, fix_div, fix_macc, fix_mul;

  assign op_in = muldiv_op_t'(req_op);
  assign sgn   = op_signed(op_in);
  assign neg_a = sgn & req_a[DATA_W-1];
  assign neg_b = sgn & req_b[DATA_W-1];
  assign abs_a = neg_a ? -req_a : req_a;
  assign abs_b = neg_b ? -req_b : req_b;

  assign prod   = {acc_q, mplr_q};
  assign prod_s = ctx_q.neg_p ? -prod : prod;
  assign quo_s  = ctx_q.neg_p ? -mplr_q : mplr_q;
  assign rem_s  = ctx_q.neg_r ? -acc_q : acc_q;

  assign fix_div0 = ctx_q.div0;
  assign fix_div  = ~ctx_q.div0 & op_is_div(ctx_q.op);
`ifdef HILO_MADD_EN
  assign fix_macc = ~ctx_q.div0 & op_is_macc(ctx_q.op);
`else
  assign fix_macc = 1'b0;
`endif
  assign fix_mul  = ~fix_div0 & ~fix_div & ~fix_macc;

`ifdef HILO_MADD_EN
  logic [2*DATA_W-1:0] hilo_acc;
  assign hilo_acc = (ctx_q.op == OP_MSUB) ? {hi_q, lo_q} - prod
                                          : {hi_q, lo_q} + prod;
`endif

  assign mode_div = (state_q == ST_DIV);

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .mode_div (mode_div),
    .acc      (acc_q),
    .mplr     (mplr_q),
    .opd      (opd_q),
    .acc_nxt  (step_acc),
    .mplr_nxt (step_mplr)
  );

  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            ctx_d = '{op: op_in, neg_p: 1'b0, neg_r: 1'b0, div0: 1'b0};
            cnt_d = CNT_LAST;
            case (op_in)
              OP_MTHI: begin
                hi_d   = req_a;
                done_d = 1'b1;
              end
              OP_MTLO: begin
                lo_d   = req_a;
                done_d = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (req_b == '0) begin
                  ctx_d.div0 = 1'b1;
                  acc_d      = req_a;
                  state_d    = ST_FIX;
                end else begin
                  ctx_d.neg_p = neg_a ^ neg_b;
                  ctx_d.neg_r = neg_a;
                  acc_d       = '0;
                  mplr_d      = abs_a;
                  opd_d       = abs_b;
                  state_d     = ST_DIV;
                end
              end
`ifdef HILO_MADD_EN
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
              OP_MADD, OP_MSUB: begin
                done_d = 1'b1;
              end
              OP_MULT, OP_MULTU: begin
`endif
                ctx_d.neg_p = neg_a ^ neg_b;
                acc_d       = '0;
                mplr_d      = abs_b;
                opd_d       = abs_a;
                state_d     = ST_MUL;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          acc_d  = step_acc;
          mplr_d = step_mplr;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          unique case (1'b1)
            fix_div0: begin
              hi_d   = acc_q;
              lo_d   = '1;
              dbz_d  = 1'b1;
              done_d = 1'b1;
            end
            fix_div: begin
              hi_d   = rem_s;
              lo_d   = quo_s;
              done_d = 1'b1;
            end
`ifdef HILO_MADD_EN
            fix_macc: begin
              {acc_d, mplr_d} = prod_s;
              state_d         = ST_ACC;
            end
`endif
            fix_mul: begin
              {hi_d, lo_d} = prod_s;
              done_d       = 1'b1;
            end
            default: ;
          endcase
        end
`ifdef HILO_MADD_EN
        ST_ACC: begin
          {hi_d, lo_d} = hilo_acc;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctx_q   <= '{op: OP_MULT, neg_p: 1'b0, neg_r: 1'b0, div0: 1'b0};
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      opd_q   <= '0;
      hi_q    <= RST_W;
      lo_q    <= RST_W;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) & ~flush;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule
